// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared register-file and hazard FSM types for the CPU pipeline.
package hazard_stall_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef enum logic [1:0] {RUN, WAIT_MEM, FAULT} hazard_state_t;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-to-hazard-controller bundle; master is the pipeline, slave the controller.
// Stats signals exist only when HAZARD_STATS_EN is defined.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;
    logic [REG_ADDR_W-1:0] id_reg_read_addr1_i;
    logic [REG_ADDR_W-1:0] id_reg_read_addr2_i;
    logic                  id_uses_reg2_i;
    logic [REG_ADDR_W-1:0] ex_reg_write_addr_i;
    logic                  ex_mem_read_ctrl_i;
    logic                  mem_req_i;
    logic                  mem_ack_i;
    logic                  pc_stall_o;
    logic                  if_id_stall_o;
    logic                  id_ex_stall_o;
    logic                  id_ex_bubble_o;
    logic                  ex_mem_stall_o;
    logic                  mem_timeout_o;
`ifdef HAZARD_STATS_EN
    logic [31:0]           stall_cycles_o;
    logic [31:0]           bubble_cnt_o;
`endif
    modport master (
        output id_reg_read_addr1_i, id_reg_read_addr2_i, id_uses_reg2_i,
               ex_reg_write_addr_i, ex_mem_read_ctrl_i, mem_req_i, mem_ack_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, id_ex_bubble_o,
               ex_mem_stall_o, mem_timeout_o
`ifdef HAZARD_STATS_EN
               , stall_cycles_o, bubble_cnt_o
`endif
    );
    modport slave (
        input  id_reg_read_addr1_i, id_reg_read_addr2_i, id_uses_reg2_i,
               ex_reg_write_addr_i, ex_mem_read_ctrl_i, mem_req_i, mem_ack_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, id_ex_bubble_o,
               ex_mem_stall_o, mem_timeout_o
`ifdef HAZARD_STATS_EN
               , stall_cycles_o, bubble_cnt_o
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl_load_use.sv
// load_use_detect: flags an ID instruction reading the register a pending load in ID/EX writes.
// Kept standalone so the forwarding unit can share it.
module load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic                  uses_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_i,
    input  logic                  ex_mem_read_i,
    output logic                  load_use_o
);
    assign load_use_o = ex_mem_read_i & (ex_wr_i != REG_ZERO) &
                        ((rs_i == ex_wr_i) | (uses_rt_i & (rt_i == ex_wr_i)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble insertion, memory-wait freeze and wait-timeout trap.
// Define HAZARD_STATS_EN to add stall/bubble event counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic [CW-1:0] SAT = '1;

    hazard_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q;
    logic          load_use, mem_wait, full, lu;

    load_use_detect u_lud (
        .rs_i          (bus.id_reg_read_addr1_i),
        .rt_i          (bus.id_reg_read_addr2_i),
        .uses_rt_i     (bus.id_uses_reg2_i),
        .ex_wr_i       (bus.ex_reg_write_addr_i),
        .ex_mem_read_i (bus.ex_mem_read_ctrl_i),
        .load_use_o    (load_use)
    );

    // A dropped request counts as an ack, so outside FAULT the freeze is just mem_wait.
    assign mem_wait = bus.mem_req_i & ~bus.mem_ack_i;
    assign full     = ~rst_i & (mem_wait | (state_q == FAULT));
    assign lu       = ~rst_i & ~full & load_use;

    assign bus.pc_stall_o     = full | lu;
    assign bus.if_id_stall_o  = full | lu;
    assign bus.id_ex_stall_o  = full;
    assign bus.ex_mem_stall_o = full;
    assign bus.id_ex_bubble_o = lu;
    assign bus.mem_timeout_o  = timeout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN && mem_wait) begin
            state_d = WAIT_MEM;
            cnt_d   = CW'(1);
        end else if (state_q == WAIT_MEM) begin
            if (!mem_wait) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
                if (MAX_WAIT != 0 && cnt_q >= LIMIT)
                    state_d = FAULT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= (state_d == FAULT);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, bubble_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'd0, full};
            bubble_cnt_q   <= bubble_cnt_q + {31'd0, lu};
        end
    end

    assign bus.stall_cycles_o = stall_cycles_q;
    assign bus.bubble_cnt_o   = bubble_cnt_q;
`endif
endmodule
